// File: rtl/pulse_xfer_scheduler.sv
// pulse_xfer_scheduler: round-robin scheduler that shares one pulse
// crossing channel between G_REQS requesters, with a holdoff after each pulse.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_req       single-cycle request pulses, one bit per requester
//   o_pulse     one-cycle pulse to the crossing channel
//   o_sel       index of the granted requester (data-mux select)
//   o_busy      high whenever the FSM is not idle
//   o_pending   registered pending-request vector
//   o_drop_cnt  saturating count of merged requests
//               (only with PULSE_XFER_SCHED_DROP_CNT_EN defined)
//
// Optional feature macro: PULSE_XFER_SCHED_DROP_CNT_EN
module pulse_xfer_scheduler #(
    parameter int G_REQS    = 4,
    parameter int G_HOLDOFF = 6,
    parameter int G_DROP_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [G_REQS-1:0]         i_req,
    output logic                      o_pulse,
    output logic [$clog2(G_REQS)-1:0] o_sel,
    output logic                      o_busy,
    output logic [G_REQS-1:0]         o_pending
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
    ,
    output logic [G_DROP_W-1:0]       o_drop_cnt
`endif
);

    localparam int SEL_W = $clog2(G_REQS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    state_t            state_q;
    logic              pulse_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [7:0]        cnt_q;
    logic [G_REQS-1:0] pend_q;

    logic [G_REQS-1:0] pend_d;
    logic [G_REQS-1:0] clr_vec;
    logic [SEL_W-1:0]  win;
    logic [SEL_W-1:0]  ptr_d;
    logic              found;
    logic              any_pend;
    logic              take;

    assign any_pend = |pend_q;

    // A new grant happens from IDLE, or from HOLD once the holdoff is spent.
    assign take = any_pend &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_HOLD) && (cnt_q == 8'd0)));

    // Round-robin search starting at ptr_q, wrapping at G_REQS-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < G_REQS; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % G_REQS;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = win + 1'b1;
        if (int'(win) == G_REQS - 1) begin
            ptr_d = '0;
        end
    end

    always_comb begin
        clr_vec = '0;
        if (take) begin
            clr_vec[win] = 1'b1;
        end
    end

    // Set wins over clear, so a request arriving on its own grant edge
    // stays pending and is served again later.
    assign pend_d = (pend_q & ~clr_vec) | i_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            pend_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            pulse_q <= 1'b0;
            if (take) begin
                state_q <= ST_ISSUE;
                pulse_q <= 1'b1;
                sel_q   <= win;
                ptr_q   <= ptr_d;
                // One ISSUE cycle, then G_HOLDOFF HOLD cycles ending at 0.
                cnt_q   <= 8'(G_HOLDOFF - 1);
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ISSUE: begin
                        state_q <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_pulse   = pulse_q;
    assign o_sel     = sel_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_pending = pend_q;

`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
    localparam int SUM_W = G_DROP_W + 5;

    logic [G_DROP_W-1:0] drop_q;
    logic [G_DROP_W-1:0] drop_d;
    logic [G_REQS-1:0]   drop_vec;
    logic [4:0]          npop;
    logic [SUM_W-1:0]    drop_sum;

    // A request merges when its bit is already pending and not being
    // cleared on this edge.
    assign drop_vec = i_req & pend_q & ~clr_vec;

    always_comb begin
        npop = 5'd0;
        for (int i = 0; i < G_REQS; i++) begin
            npop = npop + 5'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(npop);
        drop_d   = drop_sum[G_DROP_W-1:0];
        if (drop_sum > SUM_W'({G_DROP_W{1'b1}})) begin
            drop_d = {G_DROP_W{1'b1}};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pulse_xfer_scheduler.sv
// tb_pulse_xfer_scheduler: directed self-checking bench for
// pulse_xfer_scheduler (G_REQS=4, G_HOLDOFF=6).
module tb_pulse_xfer_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0;
    logic       pulse;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] pend;

    logic       s_rst_n = 1'b1;
    logic [3:0] s_req = 4'b0;
    logic       s_pulse;
    logic [1:0] s_sel;
    logic       s_busy;
    logic [3:0] s_pend;

`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
    logic [7:0] drop;
    logic [1:0] s_drop;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_xfer_scheduler #(
        .G_REQS(4), .G_HOLDOFF(6), .G_DROP_W(8)
    ) u_dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req(req),
        .o_pulse(pulse),
        .o_sel(sel),
        .o_busy(busy),
        .o_pending(pend)
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
        ,
        .o_drop_cnt(drop)
`endif
    );

    pulse_xfer_scheduler #(
        .G_REQS(4), .G_HOLDOFF(6), .G_DROP_W(2)
    ) u_sat (
        .i_clk(clk),
        .i_rst_n(s_rst_n),
        .i_req(s_req),
        .o_pulse(s_pulse),
        .o_sel(s_sel),
        .o_busy(s_busy),
        .o_pending(s_pend)
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
        ,
        .o_drop_cnt(s_drop)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 4'b0;
        s_req   = 4'b0;
        rst_n   = 1'b0;
        s_rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n   = 1'b0;
        s_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_pulse: got %b want 0", pulse);
        end
        n_cmp++;
        if (sel !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_sel: got %0d want 0", sel);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (pend !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_pend: got %b want 0000", pend);
        end
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
        n_cmp++;
        if (drop !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_drop: got %0d want 0", drop);
        end
`endif
        tick();
        tick();
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
    endtask

    task automatic test_single();
        int np;
        int nlow;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        n_cmp++;
        if (pend !== 4'b0001 || pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pend: got pend=%b pulse=%b want 0001/0",
                     pend, pulse);
        end
        tick();
        n_cmp++;
        if (pulse !== 1'b1 || sel !== 2'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_issue: got p=%b s=%0d b=%b want 1/0/1",
                     pulse, sel, busy);
        end
        n_cmp++;
        if (pend !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_clr: got %b want 0000", pend);
        end
        np   = 0;
        nlow = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (pulse === 1'b1) np++;
            if (busy !== 1'b1) nlow++;
        end
        n_cmp++;
        if (np != 0 || nlow != 0) begin
            n_bad++;
            $display("FAIL single_hold: got pulses=%0d idle=%0d want 0/0",
                     np, nlow);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: got b=%b p=%b want 0/0",
                     busy, pulse);
        end
    endtask

    task automatic test_all_simultaneous();
        int         np;
        int         exp_t [4];
        logic [1:0] exp_s [4];
        logic [3:0] exp_p [4];
        exp_t = '{1, 8, 15, 22};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_p = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        np  = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (pulse === 1'b1) begin
                if (np < 4) begin
                    n_cmp++;
                    if (t != exp_t[np] || sel !== exp_s[np]) begin
                        n_bad++;
                        $display("FAIL all_pulse%0d: got t=%0d s=%0d want t=%0d s=%0d",
                                 np, t, sel, exp_t[np], exp_s[np]);
                    end
                    n_cmp++;
                    if (pend !== exp_p[np]) begin
                        n_bad++;
                        $display("FAIL all_pend%0d: got %b want %b",
                                 np, pend, exp_p[np]);
                    end
                end
                np++;
            end
        end
        n_cmp++;
        if (np != 4 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL all_count: got n=%0d b=%b want 4/0", np, busy);
        end
    endtask

    task automatic test_round_robin();
        int         np;
        logic [3:0] tbl [32];
        int         exp_t [3];
        logic [1:0] exp_s [3];
        exp_t = '{1, 8, 15};
        exp_s = '{2'd2, 2'd0, 2'd2};
        for (int i = 0; i < 32; i++) tbl[i] = 4'b0000;
        tbl[0] = 4'b0100;
        tbl[2] = 4'b0101;
        do_reset();
        np = 0;
        for (int t = 0; t < 30; t++) begin
            req = tbl[t];
            tick();
            if (pulse === 1'b1) begin
                if (np < 3) begin
                    n_cmp++;
                    if (t != exp_t[np] || sel !== exp_s[np]) begin
                        n_bad++;
                        $display("FAIL rr_pulse%0d: got t=%0d s=%0d want t=%0d s=%0d",
                                 np, t, sel, exp_t[np], exp_s[np]);
                    end
                end
                np++;
            end
        end
        req = 4'b0000;
        n_cmp++;
        if (np != 3) begin
            n_bad++;
            $display("FAIL rr_count: got %0d want 3", np);
        end
        n_cmp++;
        if (sel !== 2'd2 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_idle_sel: got s=%0d b=%b want 2/0", sel, busy);
        end
    endtask

    task automatic test_merge();
        int         np;
        logic [3:0] tbl [32];
        int         exp_t [3];
        logic [1:0] exp_s [3];
        exp_t = '{1, 8, 15};
        exp_s = '{2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 32; i++) tbl[i] = 4'b0000;
        tbl[0] = 4'b0001;
        tbl[3] = 4'b0010;
        tbl[4] = 4'b0010;
        tbl[8] = 4'b0010;
        do_reset();
        np = 0;
        for (int t = 0; t < 30; t++) begin
            req = tbl[t];
            tick();
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
            if (t == 3 || t == 4 || t == 8) begin
                n_cmp++;
                if (drop !== ((t == 3) ? 8'd0 : 8'd1)) begin
                    n_bad++;
                    $display("FAIL merge_drop_t%0d: got %0d want %0d",
                             t, drop, (t == 3) ? 0 : 1);
                end
            end
`endif
            if (pulse === 1'b1) begin
                if (np < 3) begin
                    n_cmp++;
                    if (t != exp_t[np] || sel !== exp_s[np]) begin
                        n_bad++;
                        $display("FAIL merge_pulse%0d: got t=%0d s=%0d want t=%0d s=%0d",
                                 np, t, sel, exp_t[np], exp_s[np]);
                    end
                end
                np++;
            end
        end
        req = 4'b0000;
        n_cmp++;
        if (np != 3) begin
            n_bad++;
            $display("FAIL merge_count: got %0d want 3", np);
        end
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
        n_cmp++;
        if (drop !== 8'd1) begin
            n_bad++;
            $display("FAIL merge_drop_end: got %0d want 1", drop);
        end
`endif
    endtask

`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            s_req = (t == 0) ? 4'b0001 :
                    (t >= 2 && t <= 7) ? 4'b0010 : 4'b0000;
            tick();
            if (t == 4) begin
                n_cmp++;
                if (s_drop !== 2'd2) begin
                    n_bad++;
                    $display("FAIL sat_mid: got %0d want 2", s_drop);
                end
            end
        end
        s_req = 4'b0000;
        n_cmp++;
        if (s_drop !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_end: got %0d want 3", s_drop);
        end
    endtask
`endif

    task automatic test_reset_mid_hold();
        int np;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            req = (t == 0) ? 4'b0100 :
                  (t == 2) ? 4'b0110 : 4'b0000;
            tick();
        end
        req = 4'b0000;
        n_cmp++;
        if (busy !== 1'b1 || pend !== 4'b0110 || sel !== 2'd2) begin
            n_bad++;
            $display("FAIL mid_pre: got b=%b p=%b s=%0d want 1/0110/2",
                     busy, pend, sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pulse !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_ctl: got p=%b b=%b want 0/0",
                     pulse, busy);
        end
        n_cmp++;
        if (pend !== 4'b0000 || sel !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_rst_dat: got p=%b s=%0d want 0000/0",
                     pend, sel);
        end
        tick();
        rst_n = 1'b1;
        np = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (pulse === 1'b1 || busy === 1'b1) np++;
        end
        n_cmp++;
        if (np != 0) begin
            n_bad++;
            $display("FAIL mid_quiet: got %0d active cycles want 0", np);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1000;
        tick();
        req   = 4'b0000;
        tick();
        n_cmp++;
        if (pulse !== 1'b1 || sel !== 2'd3) begin
            n_bad++;
            $display("FAIL first_edge: got p=%b s=%0d want 1/3",
                     pulse, sel);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_simultaneous();
        test_round_robin();
        test_merge();
`ifdef PULSE_XFER_SCHED_DROP_CNT_EN
        test_saturation();
`endif
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_xfer_scheduler.md
PULSE_XFER_SCHEDULER -- requirements
Module: pulse_xfer_scheduler

Interface
REQ-001 Parameter G_REQS, default 4: number of pulse requesters sharing one crossing channel; legal range 2..16.
REQ-002 Parameter G_HOLDOFF, default 6: cycles the selection is held after each issued pulse; legal range 3..255.
REQ-003 Parameter G_DROP_W, default 8: width of the drop counter.
REQ-004 i_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 i_req  input  G_REQS: single-cycle request pulses, one bit per requester.
REQ-007 o_pulse  output  1: one-cycle pulse to the downstream pulse-crossing channel.
REQ-008 o_sel  output  $clog2(G_REQS): index of the granted requester; drives the data-mux select.
REQ-009 o_busy  output  1: high whenever the FSM is not in IDLE.
REQ-010 o_pending  output  G_REQS: registered pending-request vector.
REQ-011 o_drop_cnt  output  G_DROP_W: merged-request count; present only per REQ-027.

Function
REQ-012 The block SHALL hold one pending bit per requester; i_req[k]=1 sets pending[k] at the next edge.
REQ-013 If i_req[k]=1 while pending[k]=1 and pending[k] is not cleared that cycle, the request SHALL merge, and one drop event is counted.
REQ-014 FSM states SHALL be IDLE, ISSUE and HOLD: IDLE->ISSUE when any pending bit is set; ISSUE->HOLD always; HOLD->ISSUE when holdoff expires with any pending bit set, otherwise HOLD->IDLE.
REQ-015 On entering ISSUE, the winner SHALL be the first set pending bit searched round-robin from pointer ptr upward with wrap from G_REQS-1 to 0.
REQ-016 On entering ISSUE, o_sel SHALL load the winner, pending[winner] SHALL clear, and ptr SHALL load (winner+1) mod G_REQS.
REQ-017 If i_req[winner] is high in the cycle pending[winner] clears, set SHALL win and no drop SHALL be counted.
REQ-018 o_pulse SHALL be high for exactly the one cycle spent in ISSUE.
REQ-019 HOLD SHALL last exactly G_HOLDOFF cycles, counted by a down-counter loaded on ISSUE entry.
REQ-020 The minimum spacing between o_pulse assertions SHALL be 1+G_HOLDOFF cycles.
REQ-021 o_sel SHALL change only on ISSUE entry and SHALL otherwise hold its value, including in IDLE.
REQ-022 Latency: with the FSM idle, i_req sampled at edge N SHALL produce o_pulse high from edge N+1 to edge N+2.
REQ-023 Simultaneous requests SHALL each be served once, in round-robin order, with none lost.

Reset
REQ-024 Assertion of i_rst_n=0 SHALL immediately force: state IDLE, o_pulse 0, o_sel 0, o_busy 0, o_pending 0, ptr 0, holdoff counter 0, o_drop_cnt 0.
REQ-025 Reset asserted mid-ISSUE or mid-HOLD SHALL discard all pending requests, and no pulse SHALL be emitted after release until a new i_req arrives.
REQ-026 After deassertion, the first edge SHALL sample i_req normally.

Configuration
REQ-027 With macro PULSE_XFER_SCHED_DROP_CNT_EN defined, o_drop_cnt SHALL exist and add the number of drop events in each cycle (popcount), saturating at all-ones.
REQ-028 Without PULSE_XFER_SCHED_DROP_CNT_EN, the o_drop_cnt port and its logic SHALL be absent, and merging behaviour SHALL be unchanged.

Verification (G_REQS=4, G_HOLDOFF=6, macro defined)
REQ-029 Single request: i_req=0001 at edge 10 -> o_pulse high in cycle 11 only, o_sel=0, o_busy high for cycles 11..17, then IDLE.
REQ-030 All requesters simultaneously: i_req=1111 at edge 10 -> pulses in cycles 11, 18, 25 and 32 with o_sel 0, 1, 2, 3, and o_pending decrementing accordingly.
REQ-031 Round-robin fairness: after a grant to requester 2, pending=0101 -> next o_sel=0, then 2.
REQ-032 Merge: i_req=0010 at edges 10 and 11 while a grant to 0 is holding -> one pulse for requester 1, o_drop_cnt=1; set-over-clear at the ISSUE cycle gives no drop.
REQ-033 Saturation: G_DROP_W=2 and 5 merges -> o_drop_cnt=3.
REQ-034 Reset mid-HOLD with pending=0110 -> all outputs 0; no o_pulse within 20 cycles of release without new i_req.
